audio_fx_mixer: RTL and testbench
=================================

Name: audio_fx_mixer

Overview:
- Parametrised per-channel dry/wet mixer between the codec's ADC streaming sources and its DAC streaming sinks.
- Generalises the fixed two-channel latch-and-add path to NUM_CH independent channels, each a one-sample buffer with full valid/ready handshakes.
- Adds a configurable wet attenuation shift, saturating arithmetic, and mute.
- Adds an FX-return timeout so a stalled effect engine (e.g. one waiting on SDRAM) never stalls the DAC.

Parameters:
- DATA_W, 16: sample width, signed two's complement.
- NUM_CH, 2: number of independent audio channels (0 = left, 1 = right).
- SHIFT_W, 3: width of wet_shift.
- FX_TIMEOUT, 1024: cycles to wait for the FX return before falling back to dry-only output; must be ≥ 2.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  reset, asynchronous, active-high.
- adc_data  in  NUM_CH*DATA_W  dry sample per channel; channel c occupies bits [c*DATA_W +: DATA_W].
- adc_valid  in  NUM_CH  per-channel source valid.
- adc_ready  out  NUM_CH  per-channel ready to accept a dry sample.
- fx_tx_data  out  NUM_CH*DATA_W  captured dry sample forwarded to the FX engine.
- fx_tx_valid  out  NUM_CH  one-cycle pulse per captured dry sample, only when fx_en was sampled high.
- fx_rx_data  in  NUM_CH*DATA_W  wet sample returned by the FX engine.
- fx_rx_valid  in  NUM_CH  wet sample valid.
- fx_rx_ready  out  NUM_CH  high while the channel waits for a wet sample.
- dac_data  out  NUM_CH*DATA_W  mixed output sample.
- dac_valid  out  NUM_CH  output valid.
- dac_ready  in  NUM_CH  DAC sink ready.
- fx_en  in  1  enable wet path.
- wet_shift  in  SHIFT_W  arithmetic right shift applied to the wet sample.
- mute  in  1  force output samples to 0.
- flag_clr  in  1  clear sticky flags.
- clip_flag  out  NUM_CH  sticky: saturation occurred.
- timeout_flag  out  NUM_CH  sticky: FX return timed out.

Behaviour:
- Each channel runs its own FSM with states IDLE, WAIT_FX and OUT. Channels share only fx_en, wet_shift, mute and flag_clr.
- Reset (asynchronous) puts every channel in IDLE:
  - adc_ready = all 1.
  - dac_valid, fx_rx_ready, fx_tx_valid, flags = 0.
  - dac_data, fx_tx_data = 0; timeout counters = 0.
  - Asserting rst mid-operation discards held samples. No output is produced for them.
- Port decode: adc_ready[c] = (state==IDLE), fx_rx_ready[c] = (state==WAIT_FX), dac_valid[c] = (state==OUT). All are registered-state decodes.
- IDLE, on adc_valid & adc_ready:
  - Latch the dry sample. fx_en, wet_shift and mute are sampled in this cycle and held for that sample.
  - If fx_en is high: go to WAIT_FX, pulse fx_tx_valid for 1 cycle, drive fx_tx_data with the dry sample, clear the counter.
  - If fx_en is low: go to OUT with dac_data = dry (0 if mute). Latency is 1 cycle from handshake to dac_valid.
- WAIT_FX:
  - On fx_rx_valid: out = sat(dry + (wet >>> wet_shift)), then go to OUT (1 cycle later dac_valid). The sum is computed at DATA_W+1 bits and saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Saturation sets clip_flag[c]. mute forces 0 and suppresses clip_flag.
  - Otherwise the counter increments. When the counter reaches FX_TIMEOUT-1 with fx_rx_valid low: out = dry (0 if mute), set timeout_flag[c], go to OUT.
  - If fx_rx_valid arrives in the same cycle the timeout would fire, the wet sample wins and no timeout is flagged.
  - A late wet sample arriving after a timeout is ignored (fx_rx_ready is low).
- OUT:
  - dac_data is held stable while dac_valid & !dac_ready.
  - On dac_ready: go to IDLE, so adc_ready rises the next cycle. There is no same-cycle pass-through, giving a maximum throughput of 1 sample per 2 cycles per channel, which is ample for audio rates.
- Sticky flags:
  - flag_clr clears all clip_flag and timeout_flag bits.
  - A set event in the same cycle as flag_clr wins (the flag stays 1).
- Config changes (fx_en, wet_shift, mute) take effect only at the next ADC capture and never alter a held sample.

Test Plan:
- Bypass: fx_en=0, mute=0, adc ch0 = 16'h1234 handshake at cycle t, dac_ready=1 → dac_valid[0]=1 at t+1 with 16'h1234; adc_ready[0] returns 1 at t+2.
- Wet mix: fx_en=1, wet_shift=2, dry=1000, fx_rx=-400 → fx_tx_valid pulse with 1000; output 900 one cycle after the fx_rx handshake; ch1 is driven concurrently with independent values and stays correct.
- Saturation: wet_shift=0, dry=30000, wet=10000 → output 32767 and clip_flag[0]=1. Dry=-30000, wet=-10000 → output -32768. flag_clr coincident with a new clip → flag stays 1.
- Timeout: FX_TIMEOUT=8, fx_rx_valid never asserted → dry output 8 cycles after capture and timeout_flag set. Repeat with fx_rx_valid in exactly the timeout cycle → wet mix output and no flag.
- Backpressure/mute: dac_ready=0 for 20 cycles → dac_data stable and adc_ready=0. Toggle mute mid-hold → held data unchanged. Next sample captured with mute=1 outputs 0.
- Reset mid-operation: assert rst while in WAIT_FX and OUT → outputs reach reset values immediately (asynchronously). After release: adc_ready all 1 and no stale dac_valid.

Source files
------------

// File: rtl/audio_fx_mixer_if.sv
// Streaming bus bundle for the dry/wet mixer: ADC sources, FX send/return and DAC sinks.
// The mixer uses the master view; the surrounding codec fabric uses the slave view.
interface audio_fx_mixer_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2
);
    logic [NUM_CH*DATA_W-1:0] adc_data;
    logic [NUM_CH-1:0]        adc_valid;
    logic [NUM_CH-1:0]        adc_ready;

    logic [NUM_CH*DATA_W-1:0] fx_tx_data;
    logic [NUM_CH-1:0]        fx_tx_valid;

    logic [NUM_CH*DATA_W-1:0] fx_rx_data;
    logic [NUM_CH-1:0]        fx_rx_valid;
    logic [NUM_CH-1:0]        fx_rx_ready;

    logic [NUM_CH*DATA_W-1:0] dac_data;
    logic [NUM_CH-1:0]        dac_valid;
    logic [NUM_CH-1:0]        dac_ready;

    modport master (
        input  adc_data, adc_valid, fx_rx_data, fx_rx_valid, dac_ready,
        output adc_ready, fx_tx_data, fx_tx_valid, fx_rx_ready, dac_data, dac_valid
    );

    modport slave (
        output adc_data, adc_valid, fx_rx_data, fx_rx_valid, dac_ready,
        input  adc_ready, fx_tx_data, fx_tx_valid, fx_rx_ready, dac_data, dac_valid
    );
endinterface

// File: rtl/audio_fx_mixer.sv
// Per-channel dry/wet mixer: one-sample buffer per channel with a saturating wet mix,
// mute, sticky clip/timeout flags and an FX-return timeout that falls back to dry output.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | buffer empty, adc_ready high
// S_WAIT_FX | dry sample sent to FX engine, waiting for wet return or timeout
// S_OUT     | mixed sample presented to DAC, held until dac_ready
module audio_fx_mixer #(
    parameter int DATA_W     = 16,
    parameter int NUM_CH     = 2,
    parameter int SHIFT_W    = 3,
    parameter int FX_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    audio_fx_mixer_if.master    bus,
    input  logic                fx_en,
    input  logic [SHIFT_W-1:0]  wet_shift,
    input  logic                mute,
    input  logic                flag_clr,
    output logic [NUM_CH-1:0]   clip_flag,
    output logic [NUM_CH-1:0]   timeout_flag
);
    localparam int CNT_W = (FX_TIMEOUT > 2) ? $clog2(FX_TIMEOUT) : 1;
    // Timeout fires in the cycle the counter would advance to FX_TIMEOUT-1,
    // so dac_valid rises exactly FX_TIMEOUT cycles after the ADC handshake.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FX_TIMEOUT - 2);
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_FX = 2'd1,
        S_OUT     = 2'd2
    } state_t;

    logic [NUM_CH-1:0]        adc_ready_v;
    logic [NUM_CH-1:0]        fx_rx_ready_v;
    logic [NUM_CH-1:0]        dac_valid_v;
    logic [NUM_CH-1:0]        fx_tx_valid_v;
    logic [NUM_CH*DATA_W-1:0] dac_data_v;
    logic [NUM_CH*DATA_W-1:0] fx_tx_data_v;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t                    state_q;
        state_t                    state_nxt;
        logic signed [DATA_W-1:0]  adc_s;
        logic signed [DATA_W-1:0]  wet_s;
        logic signed [DATA_W-1:0]  wet_sh;
        logic signed [DATA_W-1:0]  mix_sat;
        logic signed [DATA_W:0]    mix_sum;
        logic signed [DATA_W-1:0]  dry_q;
        logic signed [DATA_W-1:0]  dac_q;
        logic signed [DATA_W-1:0]  fx_tx_q;
        logic [SHIFT_W-1:0]        shift_q;
        logic [CNT_W-1:0]          cnt_q;
        logic                      mute_q;
        logic                      fx_tx_vld_q;
        logic                      clip_q;
        logic                      tmo_q;
        logic                      capture;
        logic                      wet_hit;
        logic                      tmo_hit;
        logic                      ovf;
        logic                      clip_set;

        assign adc_s   = bus.adc_data[c*DATA_W +: DATA_W];
        assign wet_s   = bus.fx_rx_data[c*DATA_W +: DATA_W];
        assign wet_sh  = wet_s >>> shift_q;
        assign mix_sum = {dry_q[DATA_W-1], dry_q} + {wet_sh[DATA_W-1], wet_sh};
        assign ovf     = mix_sum[DATA_W] ^ mix_sum[DATA_W-1];
        assign mix_sat = ovf ? (mix_sum[DATA_W] ? SAT_MIN : SAT_MAX) : mix_sum[DATA_W-1:0];
        assign clip_set = wet_hit & ovf & ~mute_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= S_IDLE;
            end else begin
                state_q <= state_nxt;
            end
        end

        always_comb begin
            state_nxt = state_q;
            capture   = 1'b0;
            wet_hit   = 1'b0;
            tmo_hit   = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.adc_valid[c]) begin
                        capture   = 1'b1;
                        state_nxt = fx_en ? S_WAIT_FX : S_OUT;
                    end
                end
                S_WAIT_FX: begin
                    if (bus.fx_rx_valid[c]) begin
                        wet_hit   = 1'b1;
                        state_nxt = S_OUT;
                    end else if (cnt_q == CNT_LAST) begin
                        tmo_hit   = 1'b1;
                        state_nxt = S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.dac_ready[c]) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dry_q       <= '0;
                dac_q       <= '0;
                fx_tx_q     <= '0;
                shift_q     <= '0;
                cnt_q       <= '0;
                mute_q      <= 1'b0;
                fx_tx_vld_q <= 1'b0;
                clip_q      <= 1'b0;
                tmo_q       <= 1'b0;
            end else begin
                fx_tx_vld_q <= 1'b0;
                if (capture) begin
                    dry_q   <= adc_s;
                    shift_q <= wet_shift;
                    mute_q  <= mute;
                    cnt_q   <= '0;
                    if (fx_en) begin
                        fx_tx_vld_q <= 1'b1;
                        fx_tx_q     <= adc_s;
                    end else begin
                        dac_q <= mute ? '0 : adc_s;
                    end
                end else if (wet_hit) begin
                    dac_q <= mute_q ? '0 : mix_sat;
                end else if (tmo_hit) begin
                    dac_q <= mute_q ? '0 : dry_q;
                end else if (state_q == S_WAIT_FX) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                // A set event in the same cycle as flag_clr keeps the flag high.
                clip_q <= clip_set | (clip_q & ~flag_clr);
                tmo_q  <= tmo_hit  | (tmo_q  & ~flag_clr);
            end
        end

        assign adc_ready_v[c]   = (state_q == S_IDLE);
        assign fx_rx_ready_v[c] = (state_q == S_WAIT_FX);
        assign dac_valid_v[c]   = (state_q == S_OUT);
        assign fx_tx_valid_v[c] = fx_tx_vld_q;
        assign dac_data_v[c*DATA_W +: DATA_W]   = dac_q;
        assign fx_tx_data_v[c*DATA_W +: DATA_W] = fx_tx_q;
        assign clip_flag[c]    = clip_q;
        assign timeout_flag[c] = tmo_q;
    end

    assign bus.adc_ready   = adc_ready_v;
    assign bus.fx_rx_ready = fx_rx_ready_v;
    assign bus.dac_valid   = dac_valid_v;
    assign bus.fx_tx_valid = fx_tx_valid_v;
    assign bus.dac_data    = dac_data_v;
    assign bus.fx_tx_data  = fx_tx_data_v;
endmodule

// File: tb/tb_audio_fx_mixer.sv
// Self-checking bench for audio_fx_mixer: directed scenarios plus randomized samples
// compared against an arithmetic reference of the mix/saturate/mute rules.
module tb_audio_fx_mixer;
    localparam int DATA_W     = 16;
    localparam int NUM_CH     = 2;
    localparam int SHIFT_W    = 3;
    localparam int FX_TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fx_en, mute, flag_clr;
    logic [SHIFT_W-1:0] wet_shift;
    logic [NUM_CH-1:0]  clip_flag, timeout_flag;
    int checks   = 0;
    int failures = 0;

    audio_fx_mixer_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

    audio_fx_mixer #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .SHIFT_W(SHIFT_W), .FX_TIMEOUT(FX_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .fx_en(fx_en), .wet_shift(wet_shift),
        .mute(mute), .flag_clr(flag_clr), .clip_flag(clip_flag), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] dac(int c);
        return bus.dac_data[c*DATA_W +: DATA_W];
    endfunction

    task automatic drive_adc(int c, logic [15:0] v);
        bus.adc_data[c*DATA_W +: DATA_W] = v;
        bus.adc_valid[c] = 1'b1;
    endtask

    task automatic drive_fx(int c, logic [15:0] v);
        bus.fx_rx_data[c*DATA_W +: DATA_W] = v;
        bus.fx_rx_valid[c] = 1'b1;
    endtask

    function automatic int rand_s16();
        logic signed [15:0] r;
        r = 16'($urandom);
        return int'(r);
    endfunction

    // Reference: {clip, sample} for out = sat(dry + (wet >>> sh)), forced to 0 by mute.
    function automatic logic [16:0] ref_mix(int dry, int wet, int sh, bit m);
        int s;
        s = dry + (wet >>> sh);
        if (m) return 17'd0;
        if (s > 32767) return {1'b1, 16'h7fff};
        if (s < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(s)};
    endfunction

    task automatic test_reset();
        checks++;
        if ({bus.adc_ready, bus.dac_valid, bus.fx_rx_ready, bus.fx_tx_valid, clip_flag, timeout_flag}
            !== {2'b11, 10'b0}) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=%b", {bus.adc_ready, bus.dac_valid, bus.fx_rx_ready,
                     bus.fx_tx_valid, clip_flag, timeout_flag}, {2'b11, 10'b0});
        end
        checks++;
        if (bus.dac_data !== '0) begin
            failures++; $display("FAIL reset_dac_data got=%h exp=0", bus.dac_data);
        end
        checks++;
        if (bus.fx_tx_data !== '0) begin
            failures++; $display("FAIL reset_fx_tx_data got=%h exp=0", bus.fx_tx_data);
        end
    endtask

    task automatic test_bypass();
        fx_en = 1'b0; mute = 1'b0;
        drive_adc(0, 16'h1234);
        step();
        bus.adc_valid = '0;
        checks++;
        if (bus.dac_valid[0] !== 1'b1 || dac(0) !== 16'h1234) begin
            failures++; $display("FAIL bypass_out got v=%b d=%h exp v=1 d=1234", bus.dac_valid[0], dac(0));
        end
        checks++;
        if (bus.adc_ready[0] !== 1'b0) begin
            failures++; $display("FAIL bypass_busy adc_ready got=%b exp=0", bus.adc_ready[0]);
        end
        step();
        checks++;
        if (bus.adc_ready[0] !== 1'b1 || bus.dac_valid[0] !== 1'b0) begin
            failures++; $display("FAIL bypass_return got rdy=%b v=%b exp rdy=1 v=0", bus.adc_ready[0], bus.dac_valid[0]);
        end
        for (int n = 0; n < 16; n++) begin
            int c, dry;
            bit m;
            logic [15:0] exp_d;
            c = int'($urandom_range(0, NUM_CH-1)); dry = rand_s16(); m = 1'($urandom_range(0, 1));
            mute = m;
            drive_adc(c, 16'(dry));
            step();
            bus.adc_valid = '0;
            mute = ~m;
            exp_d = m ? 16'h0 : 16'(dry);
            checks++;
            if (bus.dac_valid[c] !== 1'b1 || dac(c) !== exp_d) begin
                failures++; $display("FAIL bypass_rand ch%0d got v=%b d=%h exp d=%h", c, bus.dac_valid[c], dac(c), exp_d);
            end
            step();
        end
        mute = 1'b0;
    endtask

    task automatic test_wet_mix();
        int d1, w1;
        logic [16:0] r;
        fx_en = 1'b1; wet_shift = 3'd2; mute = 1'b0;
        d1 = rand_s16(); w1 = rand_s16();
        drive_adc(0, 16'd1000);
        drive_adc(1, 16'(d1));
        step();
        bus.adc_valid = '0;
        wet_shift = 3'($urandom);
        checks++;
        if (bus.fx_tx_valid !== 2'b11 || bus.fx_tx_data !== {16'(d1), 16'd1000}) begin
            failures++; $display("FAIL wet_fx_tx got v=%b d=%h exp v=11 d=%h", bus.fx_tx_valid, bus.fx_tx_data, {16'(d1), 16'd1000});
        end
        checks++;
        if (bus.fx_rx_ready !== 2'b11 || bus.dac_valid !== 2'b00) begin
            failures++; $display("FAIL wet_wait got rxr=%b dv=%b exp rxr=11 dv=00", bus.fx_rx_ready, bus.dac_valid);
        end
        drive_fx(0, 16'(-400));
        step();
        bus.fx_rx_valid = '0;
        checks++;
        if (bus.fx_tx_valid !== 2'b00) begin
            failures++; $display("FAIL wet_tx_pulse got=%b exp=00", bus.fx_tx_valid);
        end
        checks++;
        if (bus.dac_valid !== 2'b01 || dac(0) !== 16'd900 || bus.fx_rx_ready !== 2'b10) begin
            failures++; $display("FAIL wet_ch0 got dv=%b d=%h rxr=%b exp dv=01 d=0384 rxr=10", bus.dac_valid, dac(0), bus.fx_rx_ready);
        end
        drive_fx(1, 16'(w1));
        step();
        bus.fx_rx_valid = '0;
        r = ref_mix(d1, w1, 2, 1'b0);
        checks++;
        if (bus.dac_valid !== 2'b10 || dac(1) !== r[15:0] || bus.adc_ready[0] !== 1'b1) begin
            failures++; $display("FAIL wet_ch1 got dv=%b d=%h exp dv=10 d=%h", bus.dac_valid, dac(1), r[15:0]);
        end
        step();
        for (int n = 0; n < 24; n++) begin
            int c, dry, wet, sh, d;
            bit m;
            c = int'($urandom_range(0, NUM_CH-1)); dry = rand_s16(); wet = rand_s16();
            sh = int'($urandom_range(0, 7)); m = ($urandom_range(0, 3) == 0);
            d = int'($urandom_range(0, FX_TIMEOUT-2));
            fx_en = 1'b1; wet_shift = 3'(sh); mute = m; flag_clr = 1'b1;
            drive_adc(c, 16'(dry));
            step();
            bus.adc_valid = '0; flag_clr = 1'b0;
            mute = ~m; wet_shift = 3'($urandom); fx_en = 1'($urandom);
            for (int i = 0; i < d; i++) step();
            drive_fx(c, 16'(wet));
            step();
            bus.fx_rx_valid = '0;
            r = ref_mix(dry, wet, sh, m);
            checks++;
            if (bus.dac_valid[c] !== 1'b1 || dac(c) !== r[15:0] || clip_flag[c] !== r[16] || timeout_flag[c] !== 1'b0) begin
                failures++;
                $display("FAIL wet_rand ch%0d dry=%0d wet=%0d sh=%0d m=%0d got v=%b d=%h clip=%b tmo=%b exp d=%h clip=%b",
                         c, dry, wet, sh, m, bus.dac_valid[c], dac(c), clip_flag[c], timeout_flag[c], r[15:0], r[16]);
            end
            step();
        end
        mute = 1'b0; fx_en = 1'b1;
    endtask

    task automatic test_saturation();
        fx_en = 1'b1; wet_shift = 3'd0; mute = 1'b0; flag_clr = 1'b1;
        step();
        drive_adc(0, 16'd30000);
        step();
        bus.adc_valid = '0;
        drive_fx(0, 16'd10000);
        step();
        bus.fx_rx_valid = '0; flag_clr = 1'b0;
        checks++;
        if (dac(0) !== 16'h7fff || clip_flag[0] !== 1'b1) begin
            failures++; $display("FAIL sat_pos got d=%h clip=%b exp d=7fff clip=1", dac(0), clip_flag[0]);
        end
        step();
        drive_adc(0, 16'(-30000));
        step();
        bus.adc_valid = '0;
        drive_fx(0, 16'(-10000));
        flag_clr = 1'b1;
        step();
        bus.fx_rx_valid = '0; flag_clr = 1'b0;
        checks++;
        if (dac(0) !== 16'h8000 || clip_flag[0] !== 1'b1) begin
            failures++; $display("FAIL sat_neg_clr got d=%h clip=%b exp d=8000 clip=1", dac(0), clip_flag[0]);
        end
        step();
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        checks++;
        if (clip_flag !== 2'b00) begin
            failures++; $display("FAIL sat_flag_clr got=%b exp=00", clip_flag);
        end
        mute = 1'b1;
        drive_adc(0, 16'd30000);
        step();
        bus.adc_valid = '0; mute = 1'b0;
        drive_fx(0, 16'd10000);
        step();
        bus.fx_rx_valid = '0;
        checks++;
        if (dac(0) !== 16'h0 || clip_flag[0] !== 1'b0) begin
            failures++; $display("FAIL sat_mute got d=%h clip=%b exp d=0000 clip=0", dac(0), clip_flag[0]);
        end
        step();
    endtask

    task automatic test_timeout();
        int dry, wet, k;
        logic [16:0] r;
        fx_en = 1'b1; mute = 1'b0; wet_shift = 3'd0; flag_clr = 1'b1;
        dry = rand_s16();
        drive_adc(1, 16'(dry));
        step();
        bus.adc_valid = '0; flag_clr = 1'b0;
        k = 1;
        while (bus.dac_valid[1] !== 1'b1 && k < 4*FX_TIMEOUT) begin
            step();
            k++;
        end
        checks++;
        if (k !== FX_TIMEOUT || dac(1) !== 16'(dry) || timeout_flag !== 2'b10) begin
            failures++; $display("FAIL timeout_dry got cycles=%0d d=%h tmo=%b exp cycles=%0d d=%h tmo=10",
                                 k, dac(1), timeout_flag, FX_TIMEOUT, 16'(dry));
        end
        bus.dac_ready[1] = 1'b0;
        drive_fx(1, 16'h7abc);
        checks++;
        if (bus.fx_rx_ready[1] !== 1'b0) begin
            failures++; $display("FAIL timeout_late_ready got=%b exp=0", bus.fx_rx_ready[1]);
        end
        step();
        bus.fx_rx_valid = '0;
        checks++;
        if (bus.dac_valid[1] !== 1'b1 || dac(1) !== 16'(dry)) begin
            failures++; $display("FAIL timeout_late_ignored got v=%b d=%h exp v=1 d=%h", bus.dac_valid[1], dac(1), 16'(dry));
        end
        bus.dac_ready[1] = 1'b1;
        step();
        dry = rand_s16(); wet = rand_s16();
        wet_shift = 3'd1; flag_clr = 1'b1;
        drive_adc(1, 16'(dry));
        step();
        bus.adc_valid = '0; flag_clr = 1'b0;
        for (int i = 0; i < FX_TIMEOUT-2; i++) step();
        checks++;
        if (bus.fx_rx_ready[1] !== 1'b1 || bus.dac_valid[1] !== 1'b0) begin
            failures++; $display("FAIL timeout_edge_wait got rxr=%b dv=%b exp rxr=1 dv=0", bus.fx_rx_ready[1], bus.dac_valid[1]);
        end
        drive_fx(1, 16'(wet));
        step();
        bus.fx_rx_valid = '0;
        r = ref_mix(dry, wet, 1, 1'b0);
        checks++;
        if (bus.dac_valid[1] !== 1'b1 || dac(1) !== r[15:0] || timeout_flag[1] !== 1'b0) begin
            failures++; $display("FAIL timeout_wet_wins got v=%b d=%h tmo=%b exp v=1 d=%h tmo=0",
                                 bus.dac_valid[1], dac(1), timeout_flag[1], r[15:0]);
        end
        step();
    endtask

    task automatic test_backpressure();
        int dry;
        fx_en = 1'b0; mute = 1'b0;
        bus.dac_ready[0] = 1'b0;
        dry = rand_s16();
        drive_adc(0, 16'(dry));
        step();
        drive_adc(0, ~16'(dry));
        for (int i = 0; i < 20; i++) begin
            if (i == 10) mute = 1'b1;
            wet_shift = 3'($urandom);
            checks++;
            if ({bus.dac_valid[0], bus.adc_ready[0], dac(0)} !== {1'b1, 1'b0, 16'(dry)}) begin
                failures++; $display("FAIL backpressure_hold cyc=%0d got v=%b rdy=%b d=%h exp v=1 rdy=0 d=%h",
                                     i, bus.dac_valid[0], bus.adc_ready[0], dac(0), 16'(dry));
            end
            step();
        end
        bus.adc_valid = '0;
        bus.dac_ready[0] = 1'b1;
        step();
        checks++;
        if (bus.adc_ready[0] !== 1'b1 || bus.dac_valid[0] !== 1'b0) begin
            failures++; $display("FAIL backpressure_release got rdy=%b v=%b exp rdy=1 v=0", bus.adc_ready[0], bus.dac_valid[0]);
        end
        drive_adc(0, 16'h4321);
        step();
        bus.adc_valid = '0; mute = 1'b0;
        checks++;
        if (bus.dac_valid[0] !== 1'b1 || dac(0) !== 16'h0) begin
            failures++; $display("FAIL backpressure_mute got v=%b d=%h exp v=1 d=0000", bus.dac_valid[0], dac(0));
        end
        step();
    endtask

    task automatic test_reset_mid();
        fx_en = 1'b1; mute = 1'b0;
        drive_adc(0, 16'd32000);
        step();
        bus.adc_valid = '0;
        fx_en = 1'b0;
        bus.dac_ready = 2'b00;
        drive_adc(1, 16'h5555);
        step();
        bus.adc_valid = '0;
        checks++;
        if (bus.fx_rx_ready !== 2'b01 || bus.dac_valid !== 2'b10 || dac(1) !== 16'h5555) begin
            failures++; $display("FAIL reset_mid_setup got rxr=%b dv=%b d1=%h exp rxr=01 dv=10 d1=5555",
                                 bus.fx_rx_ready, bus.dac_valid, dac(1));
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.adc_ready, bus.dac_valid, bus.fx_rx_ready, bus.fx_tx_valid, clip_flag, timeout_flag}
            !== {2'b11, 10'b0} || bus.dac_data !== '0 || bus.fx_tx_data !== '0) begin
            failures++; $display("FAIL reset_mid_async got rdy=%b dv=%b rxr=%b dac=%h fxtx=%h",
                                 bus.adc_ready, bus.dac_valid, bus.fx_rx_ready, bus.dac_data, bus.fx_tx_data);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.dac_ready = 2'b11;
        step();
        checks++;
        if (bus.adc_ready !== 2'b11 || bus.dac_valid !== 2'b00 || bus.fx_rx_ready !== 2'b00) begin
            failures++; $display("FAIL reset_mid_release got rdy=%b dv=%b rxr=%b exp rdy=11 dv=00 rxr=00",
                                 bus.adc_ready, bus.dac_valid, bus.fx_rx_ready);
        end
    endtask

    initial begin
        fx_en = 1'b0; mute = 1'b0; flag_clr = 1'b0; wet_shift = '0;
        bus.adc_data = '0; bus.adc_valid = '0;
        bus.fx_rx_data = '0; bus.fx_rx_valid = '0;
        bus.dac_ready = '1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        test_bypass();
        test_wet_mix();
        test_saturation();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
